// File: rtl/collision_pkg.sv
// Shared types, default parameters and width helpers for the collision arbiter.
package collision_pkg;

    // Score drain FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Default sizing shared with the top level
    localparam int DEF_T_NUM        = 4;
    localparam int DEF_A_NUM        = 8;
    localparam int DEF_MIN_OVERLAP  = 2;
    localparam int DEF_GRACE_FRAMES = 120;

    // Bits needed to hold a counter value 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n items
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/collision_torpedo_slot.sv
// One torpedo slot: first-hit latch with lowest-index asteroid target,
// plus the per-frame committed hit flag that drives torpedo_hit.
module collision_torpedo_slot
    import collision_pkg::*;
#(
    parameter int A_NUM = DEF_A_NUM
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             i_frame_start,
    input  logic             i_game_over,
    input  logic             i_draw_torpedo,
    input  logic [A_NUM-1:0] i_draw_asteroid,
    output logic             o_hit,
    output logic [A_NUM-1:0] o_kill_onehot
);

    localparam int AW = idx_width(A_NUM);

    logic          r_acc_valid;
    logic [AW-1:0] r_acc_target;
    logic          r_snap_valid;
    logic [AW-1:0] w_first_idx;
    logic          w_overlap;

    assign w_overlap = i_draw_torpedo & (|i_draw_asteroid);

    // Lowest-index priority encoder over the asteroid draw flags
    always_comb begin
        w_first_idx = '0;
        for (int a = A_NUM - 1; a >= 0; a--) begin
            if (i_draw_asteroid[a]) begin
                w_first_idx = AW'(a);
            end
        end
    end

    // Accumulate the first hit of the frame; on frame_start snapshot it and
    // restart with whatever overlap is present in that same cycle
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_acc_valid  <= 1'b0;
            r_acc_target <= '0;
            r_snap_valid <= 1'b0;
        end else if (i_frame_start) begin
            r_snap_valid <= r_acc_valid & ~i_game_over;
            r_acc_valid  <= w_overlap;
            r_acc_target <= w_first_idx;
        end else begin
            r_snap_valid <= 1'b0;
            if (w_overlap && !r_acc_valid) begin
                r_acc_valid  <= 1'b1;
                r_acc_target <= w_first_idx;
            end
        end
    end

    // One-hot kill vector presented only in the commit cycle, so the top can
    // register the asteroid events alongside the snapshot
    always_comb begin
        o_kill_onehot = '0;
        if (i_frame_start && r_acc_valid && !i_game_over) begin
            o_kill_onehot[r_acc_target] = 1'b1;
        end
    end

    assign o_hit = r_snap_valid;

endmodule

// File: rtl/collision_arbiter.sv
// Per-frame collision arbiter: ship/torpedo/asteroid overlap accumulation,
// frame-boundary event pulses, score drain and post-spawn grace period.
module collision_arbiter
    import collision_pkg::*;
#(
    parameter int T_NUM        = DEF_T_NUM,
    parameter int A_NUM        = DEF_A_NUM,
    parameter int MIN_OVERLAP  = DEF_MIN_OVERLAP,
    parameter int GRACE_FRAMES = DEF_GRACE_FRAMES
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             frame_start,
    input  logic             game_over,
    input  logic             draw_ship,
    input  logic [T_NUM-1:0] draw_torpedo,
    input  logic [A_NUM-1:0] draw_asteroid,
    output logic             ship_die,
    output logic [T_NUM-1:0] torpedo_hit,
    output logic [A_NUM-1:0] asteroid_hit,
    output logic             score_add,
    output logic             invulnerable
);

    localparam int SW = cnt_width(MIN_OVERLAP);
    localparam int GW = cnt_width(GRACE_FRAMES);
    localparam int PW = cnt_width(2 * A_NUM);
    localparam logic [PW:0] PMAX = {1'b0, {PW{1'b1}}};

    logic                w_ast_any;
    logic                w_ship_overlap;
    logic                w_ship_sat;
    logic [SW-1:0]       r_ship_cnt;
    logic                r_ship_die;
    logic [A_NUM-1:0]    w_kill [T_NUM];
    logic [A_NUM-1:0]    w_kill_any;
    logic [A_NUM-1:0]    r_asteroid_hit;
    logic [GW-1:0]       r_grace;
    logic [GW-1:0]       w_grace_next;
    logic                r_invuln;
    drain_state_t        r_state;
    drain_state_t        w_state_next;
    logic [PW-1:0]       r_pending;
    logic [PW-1:0]       w_pending_next;
    logic [PW-1:0]       w_pop;
    logic [PW:0]         w_net;
    logic                w_score_add;

    assign w_ast_any      = |draw_asteroid;
    assign w_ship_overlap = draw_ship & w_ast_any;
    assign w_ship_sat     = (r_ship_cnt >= SW'(MIN_OVERLAP));

    // One first-hit slot per torpedo
    generate
        for (genvar gi = 0; gi < T_NUM; gi++) begin : g_slot
            collision_torpedo_slot #(
                .A_NUM (A_NUM)
            ) u_slot (
                .clk             (clk),
                .resetN          (resetN),
                .i_frame_start   (frame_start),
                .i_game_over     (game_over),
                .i_draw_torpedo  (draw_torpedo[gi]),
                .i_draw_asteroid (draw_asteroid),
                .o_hit           (torpedo_hit[gi]),
                .o_kill_onehot   (w_kill[gi])
            );
        end
    endgenerate

    // Merge kills from all torpedoes: one bit per destroyed asteroid
    always_comb begin
        w_kill_any = '0;
        for (int t = 0; t < T_NUM; t++) begin
            w_kill_any = w_kill_any | w_kill[t];
        end
    end

    // Saturating ship overlap counter and registered ship_die/asteroid events
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_ship_cnt     <= '0;
            r_ship_die     <= 1'b0;
            r_asteroid_hit <= '0;
        end else begin
            r_asteroid_hit <= w_kill_any;
            if (frame_start) begin
                r_ship_die <= w_ship_sat & ~r_invuln & ~game_over;
                r_ship_cnt <= w_ship_overlap ? SW'(1) : '0;
            end else begin
                r_ship_die <= 1'b0;
                if (w_ship_overlap && !w_ship_sat) begin
                    r_ship_cnt <= r_ship_cnt + SW'(1);
                end
            end
        end
    end

    // Grace counter next value: a death reload beats a frame decrement
    always_comb begin
        w_grace_next = r_grace;
        if (r_ship_die) begin
            w_grace_next = GW'(GRACE_FRAMES);
        end else if (frame_start && (r_grace != '0)) begin
            w_grace_next = r_grace - GW'(1);
        end
    end

    // Grace counter and registered invulnerable flag
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_grace  <= GW'(GRACE_FRAMES);
            r_invuln <= (GRACE_FRAMES != 0);
        end else begin
            r_grace  <= w_grace_next;
            r_invuln <= (w_grace_next != '0);
        end
    end

    // Drain FSM next state: add this cycle's kills, retire one unit per DRAIN cycle
    always_comb begin
        w_state_next = r_state;
        w_score_add  = 1'b0;
        w_pop        = '0;
        for (int a = 0; a < A_NUM; a++) begin
            w_pop = w_pop + PW'(r_asteroid_hit[a]);
        end
        w_net = {1'b0, r_pending} + {1'b0, w_pop};
        if (r_state == DRAIN) begin
            w_score_add = 1'b1;
            w_net       = w_net - (PW + 1)'(1);
        end
        w_pending_next = (w_net > PMAX) ? PMAX[PW-1:0] : w_net[PW-1:0];
        case (r_state)
            IDLE:    if (w_pending_next != '0) w_state_next = DRAIN;
            DRAIN:   if (w_pending_next == '0) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Drain FSM state and pending-score register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    assign ship_die     = r_ship_die;
    assign asteroid_hit = r_asteroid_hit;
    assign score_add    = w_score_add;
    assign invulnerable = r_invuln;

endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench for collision_arbiter: stimulus pushes expected event
// records, a negedge monitor pops and compares whenever an output fires.
module tb_collision_arbiter;

    logic       clk = 1'b0;
    logic       resetN;
    logic       frame_start;
    logic       game_over;
    logic       draw_ship;
    logic [3:0] draw_torpedo;
    logic [7:0] draw_asteroid;
    logic       ship_die;
    logic [3:0] torpedo_hit;
    logic [7:0] asteroid_hit;
    logic       score_add;
    logic       invulnerable;

    typedef struct {
        int         cyc;
        logic       die;
        logic [3:0] th;
        logic [7:0] ah;
        logic       sa;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic presented;
    exp_t me;

    collision_arbiter dut (
        .clk           (clk),
        .resetN        (resetN),
        .frame_start   (frame_start),
        .game_over     (game_over),
        .draw_ship     (draw_ship),
        .draw_torpedo  (draw_torpedo),
        .draw_asteroid (draw_asteroid),
        .ship_die      (ship_die),
        .torpedo_hit   (torpedo_hit),
        .asteroid_hit  (asteroid_hit),
        .score_add     (score_add),
        .invulnerable  (invulnerable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every presented output against the scoreboard head
    always @(negedge clk) begin
        presented = ship_die | (|torpedo_hit) | (|asteroid_hit) | score_add;
        if (presented) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d got die=%b th=%b ah=%h sa=%b, required none",
                         cyc, ship_die, torpedo_hit, asteroid_hit, score_add);
            end else begin
                me = q.pop_front();
                if (me.cyc != cyc || me.die !== ship_die || me.th !== torpedo_hit ||
                    me.ah !== asteroid_hit || me.sa !== score_add) begin
                    n_fail++;
                    $display("FAIL event got cyc=%0d die=%b th=%b ah=%h sa=%b, required cyc=%0d die=%b th=%b ah=%h sa=%b",
                             cyc, ship_die, torpedo_hit, asteroid_hit, score_add,
                             me.cyc, me.die, me.th, me.ah, me.sa);
                end else begin
                    $display("[SB] cyc=%0d die=%b th=%b ah=%h sa=%b ok",
                             cyc, ship_die, torpedo_hit, asteroid_hit, score_add);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            n_tests++;
            n_fail++;
            me = q.pop_front();
            $display("FAIL missing_output cyc=%0d got nothing, required die=%b th=%b ah=%h sa=%b",
                     me.cyc, me.die, me.th, me.ah, me.sa);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", nm, act, req);
        end else begin
            $display("[CHK] %s = %0h ok", nm, act);
        end
    endtask

    // Drive one overlap pattern for n cycles, then release the draw flags
    task automatic draw(input logic s, input logic [3:0] t, input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            draw_ship     = s;
            draw_torpedo  = t;
            draw_asteroid = a;
            tick();
        end
        draw_ship     = 1'b0;
        draw_torpedo  = '0;
        draw_asteroid = '0;
    endtask

    // Issue frame_start and queue the hand-computed events it must produce
    task automatic commit(input logic d, input logic [3:0] t, input logic [7:0] a, input int ns);
        exp_t e;
        if (d || t != 0 || a != 0) begin
            e.cyc = cyc + 1; e.die = d; e.th = t; e.ah = a; e.sa = 1'b0;
            q.push_back(e);
        end
        for (int k = 1; k <= ns; k++) begin
            e.cyc = cyc + 1 + k; e.die = 1'b0; e.th = '0; e.ah = '0; e.sa = 1'b1;
            q.push_back(e);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        resetN        = 1'b0;
        frame_start   = 1'b0;
        game_over     = 1'b0;
        draw_ship     = 1'b0;
        draw_torpedo  = '0;
        draw_asteroid = '0;
        idle(3);
        chk("reset_ship_die", 32'(ship_die), 0);
        chk("reset_torpedo_hit", 32'(torpedo_hit), 0);
        chk("reset_asteroid_hit", 32'(asteroid_hit), 0);
        chk("reset_score_add", 32'(score_add), 0);
        chk("reset_invulnerable", 32'(invulnerable), 1);
        resetN = 1'b1;
        tick();

        // Grace period: heavy overlap on asteroid 3 is ignored while protected
        draw(1'b1, 4'b0000, 8'h08, 10);
        commit(1'b0, 4'b0000, 8'h00, 0);
        idle(2);
        for (int f = 2; f <= 119; f++) begin
            commit(1'b0, 4'b0000, 8'h00, 0);
            idle(1);
        end
        chk("grace_after_119_frames", 32'(invulnerable), 1);
        draw(1'b1, 4'b0000, 8'h08, 3);
        commit(1'b0, 4'b0000, 8'h00, 0);
        chk("grace_after_120_frames", 32'(invulnerable), 0);

        // Ship death: one pixel is not enough, two pixels kill and reload grace
        idle(2);
        draw(1'b1, 4'b0000, 8'h01, 1);
        commit(1'b0, 4'b0000, 8'h00, 0);
        idle(2);
        draw(1'b1, 4'b0000, 8'h01, 2);
        commit(1'b1, 4'b0000, 8'h00, 0);
        chk("invuln_in_die_cycle", 32'(invulnerable), 0);
        tick();
        chk("invuln_after_die", 32'(invulnerable), 1);
        for (int f = 1; f <= 119; f++) begin
            commit(1'b0, 4'b0000, 8'h00, 0);
            idle(1);
        end
        chk("reload_after_119_frames", 32'(invulnerable), 1);
        commit(1'b0, 4'b0000, 8'h00, 0);
        chk("reload_after_120_frames", 32'(invulnerable), 0);

        // Two torpedoes on asteroid 5; T0's later overlap with asteroid 1 is ignored
        idle(2);
        draw(1'b0, 4'b0101, 8'h20, 1);
        draw(1'b0, 4'b0001, 8'h02, 1);
        commit(1'b0, 4'b0101, 8'h20, 1);
        idle(4);

        // Three kills (0, 4 via lowest of 4/7, 7) drain back-to-back
        draw(1'b0, 4'b0001, 8'h01, 1);
        draw(1'b0, 4'b0010, 8'h90, 1);
        draw(1'b0, 4'b0100, 8'h80, 1);
        commit(1'b0, 4'b0111, 8'h91, 3);
        idle(6);

        // Game over suppresses ship and torpedo events
        game_over = 1'b1;
        draw(1'b1, 4'b1000, 8'h04, 3);
        commit(1'b0, 4'b0000, 8'h00, 0);
        idle(2);
        game_over = 1'b0;
        idle(2);

        // Game over rising in the event cycle leaves the pending score intact
        draw(1'b0, 4'b1000, 8'h08, 1);
        commit(1'b0, 4'b1000, 8'h08, 1);
        game_over = 1'b1;
        idle(4);
        game_over = 1'b0;
        idle(2);

        // Overlap in the frame_start cycle belongs to the next frame
        draw(1'b1, 4'b0000, 8'h01, 1);
        draw_ship     = 1'b1;
        draw_torpedo  = 4'b0001;
        draw_asteroid = 8'h01;
        commit(1'b0, 4'b0000, 8'h00, 0);
        draw_ship     = 1'b0;
        draw_torpedo  = '0;
        draw_asteroid = '0;
        idle(2);
        draw(1'b1, 4'b0000, 8'h02, 1);
        commit(1'b1, 4'b0001, 8'h01, 1);
        idle(4);
        chk("invuln_after_second_die", 32'(invulnerable), 1);

        // Reset during DRAIN drops the remaining score pulses
        draw(1'b0, 4'b0001, 8'h01, 1);
        draw(1'b0, 4'b0010, 8'h10, 1);
        draw(1'b0, 4'b0100, 8'h80, 1);
        commit(1'b0, 4'b0111, 8'h91, 1);
        tick();
        resetN = 1'b0;
        tick();
        chk("score_add_after_reset", 32'(score_add), 0);
        tick();
        resetN = 1'b1;
        idle(6);
        chk("invuln_after_midreset", 32'(invulnerable), 1);
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
